alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
//==============================================================================
// alu_arbiter - round-robin two-requester front end for a shared combinational ALU
// Rev 1.0
//==============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int N = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_out,
  input  logic [3:0]   alu_flags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_out,
  output logic [3:0]   rsp_flags,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;
  logic   grant;
  logic   grant_idx;
  logic   accept;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        accept = req0_valid | req1_valid;
        // With both pending, the requester that did not win last time goes next.
        if (req0_valid && req1_valid) begin
          grant = ~last_grant;
        end else begin
          grant = req1_valid;
        end
        req0_ready = accept & ~grant;
        req1_ready = accept & grant;
        if (accept) begin
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      grant_idx  <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      alu_a      <= grant ? req1_a  : req0_a;
      alu_b      <= grant ? req1_b  : req0_b;
      alu_op     <= grant ? req1_op : req0_op;
      grant_idx  <= grant;
      last_grant <= grant;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_out   <= '0;
      rsp_flags <= '0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_id    <= grant_idx;
      rsp_out   <= alu_out;
      rsp_flags <= alu_flags;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//==============================================================================
// tb_alu_arbiter - directed self-checking bench with an adder as the shared ALU
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_alu_arbiter;

  localparam int N = 64;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_op, req1_op;
  logic [N-1:0] alu_a, alu_b, alu_out;
  logic [3:0]   alu_op, alu_flags;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [N-1:0] rsp_out;
  logic [3:0]   rsp_flags;
  logic [N:0]   sum;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Shared ALU: adder with {negative, zero, carry_out, overflow}.
  assign sum       = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_out   = sum[N-1:0];
  assign alu_flags = {sum[N-1], (sum[N-1:0] == '0), sum[N],
                      (alu_a[N-1] == alu_b[N-1]) && (sum[N-1] != alu_a[N-1])};

  alu_arbiter #(.N(N)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_flags(rsp_flags), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = 4'h0;
    req1_a = '0; req1_b = '0; req1_op = 4'h0;
    rsp_ready = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rsp_out", rsp_out, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_rsp_id", rsp_id, 0);
    reset = 1'b0;

    // Idle with rsp_ready high and no requests
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ready0", req0_ready, 0);
    end
    rsp_ready = 1'b0;

    // Single request from requester 0: 5 + 3
    req0_valid = 1'b1; req0_a = 64'd5; req0_b = 64'd3; req0_op = 4'h2;
    #1;
    chk("r0_ready", req0_ready, 1);
    chk("r0_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("exec_ready0", req0_ready, 0);
    chk("exec_busy", busy, 1);
    chk("exec_alu_a", alu_a, 5);
    chk("exec_alu_b", alu_b, 3);
    chk("exec_alu_op", alu_op, 2);
    chk("exec_rsp_valid", rsp_valid, 0);
    tick();
    chk("r0_rsp_valid", rsp_valid, 1);
    chk("r0_rsp_out", rsp_out, 8);
    chk("r0_rsp_id", rsp_id, 0);
    chk("r0_rsp_flags", rsp_flags, 4'b0000);

    // Back-pressure: response must hold while both requesters wait
    req0_valid = 1'b1; req0_a = 64'd100; req0_b = 64'd1;
    req1_valid = 1'b1; req1_a = 64'd200; req1_b = 64'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_out", rsp_out, 8);
      chk("hold_ready0", req0_ready, 0);
      chk("hold_ready1", req1_ready, 0);
      chk("hold_busy", busy, 1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("release_rsp_valid", rsp_valid, 0);
    chk("release_busy", busy, 0);
    chk("rr_after_r0_ready1", req1_ready, 1);
    chk("rr_after_r0_ready0", req0_ready, 0);

    // Fresh reset, then continuous contention alternates 0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_a = 64'd1;    req0_b = 64'd2;    req0_op = 4'h1;
    req1_a = 64'h10;   req1_b = 64'h20;   req1_op = 4'h3;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready0", req0_ready, (k % 2 == 0) ? 1 : 0);
      chk("rr_ready1", req1_ready, (k % 2 == 1) ? 1 : 0);
      tick();
      chk("rr_no_ready_exec", req0_ready | req1_ready, 0);
      tick();
      chk("rr_rsp_valid", rsp_valid, 1);
      chk("rr_rsp_id", rsp_id, k % 2);
      chk("rr_rsp_out", rsp_out, (k % 2 == 0) ? 64'd3 : 64'h30);
      chk("rr_no_ready_resp", req0_ready | req1_ready, 0);
      tick();
      chk("rr_rsp_cleared", rsp_valid, 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Requester 1 wrap-around: all ones + 1
    req1_a = 64'hFFFF_FFFF_FFFF_FFFF; req1_b = 64'd1;
    req1_valid = 1'b1;
    #1;
    chk("wrap_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("wrap_rsp_valid", rsp_valid, 1);
    chk("wrap_rsp_out", rsp_out, 0);
    chk("wrap_rsp_flags", rsp_flags, 4'b0110);
    chk("wrap_rsp_id", rsp_id, 1);
    tick();

    // Reset during EXEC drops the operation
    req1_a = 64'd7; req1_b = 64'd7; req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    chk("pre_abort_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_alu_a", alu_a, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_abort_rsp_valid", rsp_valid, 0);
    chk("post_abort_busy", busy, 0);

    // Next request served normally, requester 0 has priority again
    req0_a = 64'd2; req0_b = 64'd2; req0_valid = 1'b1;
    req1_a = 64'd9; req1_b = 64'd9; req1_valid = 1'b1;
    #1;
    chk("prio_ready0", req0_ready, 1);
    chk("prio_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("prio_rsp_valid", rsp_valid, 1);
    chk("prio_rsp_out", rsp_out, 4);
    chk("prio_rsp_id", rsp_id, 0);
    tick();
    chk("prio_done", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
